// File: rtl/adc_fwd_pkg.sv
// Shared constants for the ADC forward path: scheduler state encoding,
// channel numbers and the default sample width.
package adc_fwd_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_ACT = 2'b01,
        WAIT_SIG = 2'b10,
        PUBLISH  = 2'b11
    } state_t;

    localparam logic CH_ACT = 1'b0;
    localparam logic CH_SIG = 1'b1;

    localparam int MISS_W = 8;

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (v == {MISS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Free-running frame timer: counts 0..PERIOD-1 while enabled, held at 0 otherwise.
// tick is high during the cycle the count sits at PERIOD-1; no backpressure.
module adc_period_timer #(
    parameter int PERIOD = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int              CW   = $clog2(PERIOD);
    localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/adc_sample_scheduler.sv
// Shares one ADC between the actual and signal inputs and publishes them as a pair.
// Frame latency 6 clocks minimum from tick; late ticks are counted, not queued.
module adc_sample_scheduler
    import adc_fwd_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PERIOD  = 100,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              adc_start,
    output logic              adc_chan,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] v_actual,
    output logic [DATA_W-1:0] v_signal,
    output logic              pair_valid,
    output logic              timeout_err,
    output logic [MISS_W-1:0] missed_ticks,
    output logic [1:0]        status
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  hold, hold_nxt;
    logic [DATA_W-1:0]  actual_nxt, signal_nxt;
    logic [WD_W-1:0]    wd_cnt, wd_nxt;
    logic [MISS_W-1:0]  miss_nxt;
    logic               start_nxt, chan_nxt, pv_nxt, terr_nxt;
    logic               enable_q;
    logic               tick, en_rise, in_wait, accept, wd_expired;

    adc_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // A done pulse coinciding with our own start request belongs to an older conversion.
    assign in_wait    = (state == WAIT_ACT) || (state == WAIT_SIG);
    assign accept     = adc_done && !adc_start && in_wait;
    assign wd_expired = (wd_cnt == WD_LAST);
    assign en_rise    = enable && !enable_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            adc_start    <= 1'b0;
            adc_chan     <= CH_ACT;
            hold         <= '0;
            v_actual     <= '0;
            v_signal     <= '0;
            pair_valid   <= 1'b0;
            timeout_err  <= 1'b0;
            missed_ticks <= '0;
            wd_cnt       <= '0;
            enable_q     <= 1'b0;
        end else begin
            state        <= state_nxt;
            adc_start    <= start_nxt;
            adc_chan     <= chan_nxt;
            hold         <= hold_nxt;
            v_actual     <= actual_nxt;
            v_signal     <= signal_nxt;
            pair_valid   <= pv_nxt;
            timeout_err  <= terr_nxt;
            missed_ticks <= miss_nxt;
            wd_cnt       <= wd_nxt;
            enable_q     <= enable;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_nxt  = 1'b0;
        chan_nxt   = adc_chan;
        hold_nxt   = hold;
        actual_nxt = v_actual;
        signal_nxt = v_signal;
        pv_nxt     = 1'b0;
        terr_nxt   = timeout_err;
        miss_nxt   = missed_ticks;
        wd_nxt     = in_wait ? wd_cnt + 1'b1 : '0;

        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state_nxt = WAIT_ACT;
                        start_nxt = 1'b1;
                        chan_nxt  = CH_ACT;
                        wd_nxt    = '0;
                    end
                end
                WAIT_ACT: begin
                    if (accept) begin
                        hold_nxt  = adc_data;
                        state_nxt = WAIT_SIG;
                        start_nxt = 1'b1;
                        chan_nxt  = CH_SIG;
                        wd_nxt    = '0;
                    end else if (wd_expired) begin
                        terr_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                WAIT_SIG: begin
                    // Both halves of the pair move on the same edge.
                    if (accept) begin
                        actual_nxt = hold;
                        signal_nxt = adc_data;
                        pv_nxt     = 1'b1;
                        state_nxt  = PUBLISH;
                        wd_nxt     = '0;
                    end else if (wd_expired) begin
                        terr_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                PUBLISH: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (en_rise) begin
            terr_nxt = 1'b0;
            miss_nxt = '0;
        end else if (tick && (state != IDLE)) begin
            miss_nxt = sat_inc(missed_ticks);
        end
    end

    assign status = state;

endmodule

// File: doc/adc_sample_scheduler.md
# adc_sample_scheduler

Sequencer that shares one ADC converter between the two regulator inputs, the actual voltage and the signal voltage, and forwards them as a coherent pair. The block fires a conversion frame every `PERIOD` clocks: it converts channel 0 (actual), then channel 1 (signal), then publishes both 16-bit results together with a one-cycle valid strobe to the adc-forward datapath. A watchdog aborts frames stuck on a silent converter. A 2-bit state output serves debug and bench sequencing.

## Interface
- `DATA_W`, 16: sample width.
- `PERIOD`, 100: clocks between frame ticks; legal range ≥ 8.
- `TIMEOUT`, 64: maximum clocks a wait state may last without `adc_done`; legal range ≥ 2.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1: the single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: run control. While low, the period counter is held at 0 and no new frame starts.
- `adc_start`  out  1: one-cycle conversion request to the ADC.
- `adc_chan`  out  1: channel select, 0 = actual, 1 = signal. Valid while `adc_start` is high; held at its last value otherwise.
- `adc_done`  in  1: conversion-complete pulse from the ADC.
- `adc_data`  in  DATA_W: conversion result, valid while `adc_done` is high.
- `v_actual`  out  DATA_W: last published actual sample.
- `v_signal`  out  DATA_W: last published signal sample.
- `pair_valid`  out  1: one-cycle strobe when `v_actual` and `v_signal` update.
- `timeout_err`  out  1: sticky watchdog flag.
- `missed_ticks`  out  8: saturating count of ticks dropped because a frame was still running.
- `status`  out  2: current state encoding.

## Operation
- **Reset values.** Every output and register resets to 0; the state resets to IDLE.
- **Period counter.** Counts 0..PERIOD-1 and wraps while `enable` is high. A tick is generated in the cycle where count == PERIOD-1.
- **State machine** (`status` encoding in parentheses):
  - IDLE (00): on a tick with `enable` high, go to WAIT_ACT, with `adc_start`=1 and `adc_chan`=0 registered.
  - WAIT_ACT (01): on `adc_done` with `adc_start` low, latch `adc_data` into an internal hold register, then go to WAIT_SIG with `adc_start`=1 and `adc_chan`=1.
  - WAIT_SIG (10): on `adc_done` with `adc_start` low, load `v_signal` from `adc_data` and `v_actual` from the hold register in the same edge, then go to PUBLISH.
  - PUBLISH (11): `pair_valid`=1 for exactly this cycle, then go to IDLE.
- **Ignored `adc_done`.** `adc_done` is ignored in IDLE and PUBLISH, and in any cycle where `adc_start` is high.
- **Missed ticks.** A tick arriving outside IDLE increments `missed_ticks`. The counter saturates at 255 and does not start a frame.
- **Watchdog.** A watchdog counter clears on entry to each wait state. If TIMEOUT clocks elapse with no accepted `adc_done`:
  - set `timeout_err`;
  - go to IDLE;
  - leave `v_actual`, `v_signal` and the hold register's published values untouched.
  If `adc_done` arrives in the same cycle the watchdog expires, `adc_done` wins.
- **Enable low mid-frame.** Return to IDLE on the next edge, discard partial data, assert no `pair_valid`, do not touch `timeout_err`.
- **Clearing flags.** `timeout_err` and `missed_ticks` clear only on reset or on a rising edge of `enable`.
- **Pair coherence.** `v_actual` and `v_signal` never update separately.

## Timing
- Tick in cycle T: `adc_start`=1 with `adc_chan`=0 in cycle T+1.
- `adc_done` accepted in WAIT_ACT in cycle D: `adc_start`=1 with `adc_chan`=1 in cycle D+1.
- `adc_done` accepted in WAIT_SIG in cycle E: outputs updated and `pair_valid`=1 in cycle E+1; IDLE in cycle E+2.
- Minimum frame, with `adc_done` arriving one cycle after each start: 6 clocks from tick to IDLE.
- All outputs are registered; no combinational path from input to output.

## Structure
- Package `adc_fwd_pkg` holds:
  - the state encoding constants (IDLE=2'b00, WAIT_ACT=2'b01, WAIT_SIG=2'b10, PUBLISH=2'b11);
  - the channel constants CH_ACT=0 and CH_SIG=1;
  - the default DATA_W.
- Sub-module `adc_period_timer` (parameter PERIOD; ports `clk`, `rst_n`, `enable`, `tick`) implements the period counter.
- The FSM, watchdog, hold register and flag logic live in the top module.

## Test plan
- **Nominal frame.** Use PERIOD=20. ADC model answers 3 clocks after each start with 16'h0006 (ch0) and 16'h0002 (ch1). Expect `v_actual`=6, `v_signal`=2 and one `pair_valid` per 20 clocks, with `status` sequence 00→01→10→11→00.
- **Missed ticks.** Use PERIOD=8. ADC latency is 10 clocks. Expect `missed_ticks` to increment once per dropped tick, and no frame to start outside IDLE.
- **Watchdog.** Use TIMEOUT=4. ADC never answers on ch1. Expect `timeout_err`=1 after 4 clocks in WAIT_SIG, return to IDLE, outputs keep their prior pair (1,1).
- **Watchdog race.** Deliver `adc_done` in the same cycle the watchdog expires. Expect the sample to be accepted and no `timeout_err`.
- **Enable dropped mid-frame.** Drop `enable` in WAIT_ACT. Expect IDLE the next cycle, no `pair_valid`, a later `adc_done` ignored. Re-enable and expect `timeout_err` and `missed_ticks` to clear to 0.
- **Asynchronous reset mid-frame.** Assert `rst_n` low in WAIT_SIG between clock edges. Expect all outputs to go to 0 immediately and `status`=00.
